// File: rtl/mlp_layer_sequencer.sv
// Layer sequencer for mlp_compute_datapath. It runs one neuron at a time and streams
// 8-lane input/weight chunks, then captures each activated neuron result.
module mlp_layer_sequencer #(
  parameter  int MAX_INPUTS  = 64,
  parameter  int MAX_NEURONS = 32,
  localparam int DATA_W      = 8,
  localparam int COEF_W      = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [$clog2(MAX_INPUTS):0]                   num_inputs,
  input  logic [$clog2(MAX_NEURONS):0]                  num_neurons,
  input  logic [1:0]                                    act_type,
  output logic                                          busy,
  output logic                                          done,
  output logic [$clog2(MAX_INPUTS/8)-1:0]               in_rd_addr,
  input  logic [8*DATA_W-1:0]                           in_rd_data,
  output logic [$clog2(MAX_NEURONS*(MAX_INPUTS/8))-1:0] w_rd_addr,
  input  logic [8*COEF_W-1:0]                           w_rd_data,
  output logic [$clog2(MAX_NEURONS)-1:0]                b_rd_addr,
  input  logic signed [DATA_W-1:0]                      b_rd_data,
  output logic                                          mac_enable,
  output logic                                          mac_clear,
  output logic                                          activation_enable,
  output logic [1:0]                                    activation_type,
  output logic [DATA_W-1:0]                             data_out [0:7],
  output logic [COEF_W-1:0]                             weight_out [0:7],
  output logic signed [DATA_W-1:0]                      bias_out,
  input  logic                                          mac_valid,
  input  logic                                          result_valid,
  input  logic [DATA_W-1:0]                             result_in,
  output logic                                          out_wr_en,
  output logic [$clog2(MAX_NEURONS)-1:0]                out_wr_addr,
  output logic [DATA_W-1:0]                             out_wr_data
);

  localparam int LANES      = 8;
  localparam int CHUNKS_MAX = MAX_INPUTS / LANES;
  localparam int NI_W       = $clog2(MAX_INPUTS) + 1;
  localparam int NN_W       = $clog2(MAX_NEURONS) + 1;
  localparam int NA_W       = $clog2(MAX_NEURONS);
  localparam int WA_W       = $clog2(MAX_NEURONS * CHUNKS_MAX);
  localparam int CA_W       = $clog2(CHUNKS_MAX);
  localparam int CC_W       = CA_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_ISSUE, S_DRAIN, S_ACT, S_WAIT_RES, S_WRITE, S_DONE
  } state_t;

  state_t           state;
  logic [NI_W-1:0]  n_in;
  logic [NN_W-1:0]  n_neu;
  logic [CC_W-1:0]  chunks;
  logic [CC_W-1:0]  chunk;
  logic [CC_W-1:0]  vcount;
  logic [NA_W-1:0]  neuron;
  logic [LANES-1:0] lane_ok;
  logic [NI_W:0]    ceil_sum;

  assign ceil_sum = {1'b0, num_inputs} + (NI_W+1)'(LANES - 1);

  function automatic logic [WA_W-1:0] w_addr(input logic [NA_W-1:0] n, input logic [CC_W-1:0] c);
    return WA_W'(n) * WA_W'(CHUNKS_MAX) + WA_W'(c);
  endfunction

  // Lanes are only live during the issue cycle; lanes past the fan-in read as zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      data_out[l]   = '0;
      weight_out[l] = '0;
      if (mac_enable && lane_ok[l]) begin
        data_out[l]   = in_rd_data[DATA_W*l +: DATA_W];
        weight_out[l] = w_rd_data[COEF_W*l +: COEF_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      mac_clear         <= 1'b0;
      mac_enable        <= 1'b0;
      activation_enable <= 1'b0;
      out_wr_en         <= 1'b0;
      activation_type   <= '0;
      in_rd_addr        <= '0;
      w_rd_addr         <= '0;
      b_rd_addr         <= '0;
      bias_out          <= '0;
      out_wr_addr       <= '0;
      out_wr_data       <= '0;
      n_in              <= '0;
      n_neu             <= '0;
      chunks            <= '0;
      chunk             <= '0;
      vcount            <= '0;
      neuron            <= '0;
      lane_ok           <= '0;
    end else begin
      done              <= 1'b0;
      mac_clear         <= 1'b0;
      mac_enable        <= 1'b0;
      activation_enable <= 1'b0;
      out_wr_en         <= 1'b0;

      // MAC returns are counted regardless of state so none are lost during ISSUE/FETCH.
      if (busy && mac_valid && (vcount < chunks))
        vcount <= vcount + CC_W'(1);

      unique case (state)
        S_IDLE: begin
          if (start) begin
            n_in            <= num_inputs;
            n_neu           <= num_neurons;
            activation_type <= act_type;
            chunks          <= CC_W'(ceil_sum >> $clog2(LANES));
            neuron          <= '0;
            busy            <= 1'b1;
            if (num_inputs == '0 || num_neurons == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_CLEAR;
              mac_clear <= 1'b1;
              b_rd_addr <= '0;
            end
          end
        end
        S_CLEAR: begin
          chunk      <= '0;
          vcount     <= '0;
          in_rd_addr <= '0;
          w_rd_addr  <= w_addr(neuron, '0);
          state      <= S_FETCH;
        end
        S_FETCH: begin
          if (chunk == '0)
            bias_out <= b_rd_data;
          for (int l = 0; l < LANES; l++)
            lane_ok[l] <= (NI_W'(chunk) * NI_W'(LANES) + NI_W'(l)) < n_in;
          mac_enable <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          chunk <= chunk + CC_W'(1);
          if (chunk == chunks - CC_W'(1)) begin
            state <= S_DRAIN;
          end else begin
            in_rd_addr <= CA_W'(chunk + CC_W'(1));
            w_rd_addr  <= w_addr(neuron, chunk + CC_W'(1));
            state      <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (vcount == chunks) begin
            activation_enable <= 1'b1;
            state             <= S_ACT;
          end
        end
        S_ACT: begin
          state <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (result_valid) begin
            out_wr_data <= result_in;
            out_wr_addr <= neuron;
            out_wr_en   <= 1'b1;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (NN_W'(neuron) == n_neu - NN_W'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            neuron    <= neuron + NA_W'(1);
            b_rd_addr <= neuron + NA_W'(1);
            mac_clear <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: buffer models, a datapath stub, and a layer-level
// reference computed directly from the buffer contents.
module tb_mlp_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  num_inputs = '0;
  logic [5:0]  num_neurons = '0;
  logic [1:0]  act_type = '0;
  logic        busy, done;
  logic [2:0]  in_rd_addr;
  logic [63:0] in_rd_data = '0;
  logic [7:0]  w_rd_addr;
  logic [63:0] w_rd_data = '0;
  logic [4:0]  b_rd_addr;
  logic signed [7:0] b_rd_data = '0;
  logic        mac_enable, mac_clear, activation_enable;
  logic [1:0]  activation_type;
  logic [7:0]  data_out [0:7];
  logic [7:0]  weight_out [0:7];
  logic signed [7:0] bias_out;
  logic        mac_valid = 1'b0;
  logic        result_valid;
  logic [7:0]  result_in;
  logic        out_wr_en;
  logic [4:0]  out_wr_addr;
  logic [7:0]  out_wr_data;

  int vectors = 0;
  int miscompares = 0;

  mlp_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_inputs(num_inputs),
    .num_neurons(num_neurons), .act_type(act_type), .busy(busy), .done(done),
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data), .w_rd_addr(w_rd_addr),
    .w_rd_data(w_rd_data), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .mac_enable(mac_enable), .mac_clear(mac_clear), .activation_enable(activation_enable),
    .activation_type(activation_type), .data_out(data_out), .weight_out(weight_out),
    .bias_out(bias_out), .mac_valid(mac_valid), .result_valid(result_valid),
    .result_in(result_in), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data)
  );

  always #5 clk = ~clk;

  // Buffers with one-cycle read latency
  logic [63:0] in_mem [0:7];
  logic [63:0] w_mem [0:255];
  logic [7:0]  b_mem [0:31];

  always @(posedge clk) begin
    in_rd_data <= in_mem[in_rd_addr];
    w_rd_data  <= w_mem[w_rd_addr];
    b_rd_data  <= b_mem[b_rd_addr];
  end

  function automatic int act_fn(input int a, input logic [1:0] t);
    int r;
    r = a;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    if (t == 2'd1 && r < 0) r = 0;
    return r;
  endfunction

  function automatic int model(input int n, input int ni, input logic [1:0] t);
    int acc;
    acc = int'($signed(b_mem[n]));
    for (int k = 0; k < ni; k++) begin
      int x;
      int w;
      x = int'($signed(in_mem[k/8][(k%8)*8 +: 8]));
      w = int'($signed(w_mem[n*8 + k/8][(k%8)*8 +: 8]));
      acc += x * w;
    end
    return act_fn(acc, t);
  endfunction

  // Datapath stub: MAC valid one cycle after enable, result res_dly cycles after activation
  int acc = 0;
  int res_cnt = 0;
  int res_dly = 1;
  logic [7:0] res_val = '0;
  assign result_valid = (res_cnt == 1);
  assign result_in    = res_val;

  function automatic int lane_sum();
    int s;
    s = 0;
    for (int l = 0; l < 8; l++) begin
      int a;
      int b;
      a = int'($signed(data_out[l]));
      b = int'($signed(weight_out[l]));
      s += a * b;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    mac_valid <= mac_enable;
    if (mac_clear) acc <= 0;
    else if (mac_enable) acc <= acc + lane_sum();
    if (activation_enable) begin
      res_cnt <= res_dly;
      res_val <= 8'(act_fn(acc + int'(bias_out), activation_type));
    end else if (res_cnt > 0) begin
      res_cnt <= res_cnt - 1;
    end
  end

  // Event monitor, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int me_q[$], mc_q[$], ae_q[$], done_q[$], wr_cyc_q[$];
  logic [7:0]   wa_q[$];
  logic [7:0]   bias_q[$];
  logic [127:0] lanes_q[$];
  logic [4:0]   wr_addr_q[$];
  logic [7:0]   wr_data_q[$];
  int viol = 0;

  always @(negedge clk) begin
    if (mac_enable) begin
      logic [127:0] p;
      for (int l = 0; l < 8; l++) begin
        p[8*l +: 8]      = data_out[l];
        p[64 + 8*l +: 8] = weight_out[l];
      end
      me_q.push_back(cyc);
      wa_q.push_back(w_rd_addr);
      bias_q.push_back(bias_out);
      lanes_q.push_back(p);
    end
    if (mac_clear) mc_q.push_back(cyc);
    if (activation_enable) ae_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (out_wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(out_wr_addr);
      wr_data_q.push_back(out_wr_data);
    end
    if ((int'(mac_clear) + int'(mac_enable) + int'(activation_enable)) > 1 ||
        (!busy && (mac_clear || mac_enable || activation_enable)))
      viol <= viol + 1;
  end

  task automatic clear_q();
    me_q.delete(); mc_q.delete(); ae_q.delete(); done_q.delete(); wr_cyc_q.delete();
    wa_q.delete(); bias_q.delete(); lanes_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) in_mem[i] = {$urandom, $urandom};
    for (int i = 0; i < 256; i++) w_mem[i] = {$urandom, $urandom};
    for (int i = 0; i < 32; i++) b_mem[i] = 8'($urandom);
  endtask

  // Pulses start, optionally re-pulses it mid-run with a different config, waits for done.
  task automatic run_layer(input int ni, input int nn, input logic [1:0] at, input int dly,
                           input int repulse_at, output int t0, output bit timed_out);
    clear_q();
    res_dly = dly;
    @(posedge clk); #1;
    num_inputs = 7'(ni); num_neurons = 6'(nn); act_type = at; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int k = 1; k < 3000; k++) begin
      if (k == repulse_at) begin
        start = 1'b1; num_inputs = 7'd40; num_neurons = 6'd5;
      end else if (k == repulse_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, mac_clear, mac_enable, activation_enable, out_wr_en} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, done, mac_clear, mac_enable, activation_enable, out_wr_en});
    end
    vectors++;
    if ({in_rd_addr, w_rd_addr, b_rd_addr, out_wr_addr} !== 21'b0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h want 0", {in_rd_addr, w_rd_addr, b_rd_addr, out_wr_addr});
    end
    vectors++;
    if ({bias_out, out_wr_data, activation_type, data_out[0], weight_out[7]} !== 34'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0",
               {bias_out, out_wr_data, activation_type, data_out[0], weight_out[7]});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_neuron();
    int t0;
    bit to;
    fill_random();
    in_mem[0] = 64'h0101010101010101;
    w_mem[0]  = 64'h0202020202020202;
    b_mem[0]  = 8'd0;
    run_layer(8, 1, 2'd0, 1, -1, t0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL single_timeout: got %b want 0", to); end
    vectors++;
    if (mc_q.size() != 1 || mc_q[0] - t0 != 1) begin
      miscompares++; $display("FAIL single_clear_cycle: got n=%0d want one pulse at c1", mc_q.size());
    end
    vectors++;
    if (me_q.size() != 1 || me_q[0] - t0 != 3) begin
      miscompares++; $display("FAIL single_mac_enable_cycle: got n=%0d want one pulse at c3", me_q.size());
    end
    vectors++;
    if (ae_q.size() != 1 || ae_q[0] - t0 != 6) begin
      miscompares++; $display("FAIL single_act_cycle: got n=%0d want one pulse at c6", ae_q.size());
    end
    vectors++;
    if (wr_cyc_q.size() != 1 || wr_cyc_q[0] - t0 != 8 || wr_addr_q[0] !== 5'd0 || wr_data_q[0] !== 8'd16) begin
      miscompares++; $display("FAIL single_write: got n=%0d want one write at c8 addr 0 data 16", wr_cyc_q.size());
    end
    vectors++;
    if (done_q.size() != 1 || done_q[0] - t0 != 9) begin
      miscompares++; $display("FAIL single_done_cycle: got n=%0d want one pulse at c9", done_q.size());
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_partial_chunk();
    int t0;
    bit to;
    fill_random();
    run_layer(20, 2, 2'(($urandom)), 1, -1, t0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL partial_timeout: got %b want 0", to); end
    vectors++;
    if (me_q.size() != 6) begin
      miscompares++; $display("FAIL partial_issue_count: got %0d want 6", me_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        int n;
        int c;
        logic [127:0] ex;
        n = i / 3;
        c = i % 3;
        ex = '0;
        for (int l = 0; l < 8; l++)
          if (c*8 + l < 20) begin
            ex[8*l +: 8]      = in_mem[c][8*l +: 8];
            ex[64 + 8*l +: 8] = w_mem[n*8 + c][8*l +: 8];
          end
        vectors++;
        if (wa_q[i] !== 8'(n*8 + c)) begin
          miscompares++; $display("FAIL partial_waddr[%0d]: got %0d want %0d", i, wa_q[i], n*8 + c);
        end
        vectors++;
        if (lanes_q[i] !== ex) begin
          miscompares++; $display("FAIL partial_lanes[%0d]: got %h want %h", i, lanes_q[i], ex);
        end
        vectors++;
        if (bias_q[i] !== b_mem[n]) begin
          miscompares++; $display("FAIL partial_bias[%0d]: got %h want %h", i, bias_q[i], b_mem[n]);
        end
      end
    end
    vectors++;
    if (wr_addr_q.size() != 2) begin
      miscompares++; $display("FAIL partial_write_count: got %0d want 2", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== 8'(model(i, 20, act_type))) begin
          miscompares++;
          $display("FAIL partial_write[%0d]: got addr %0d data %h want addr %0d data %h",
                   i, wr_addr_q[i], wr_data_q[i], i, 8'(model(i, 20, act_type)));
        end
      end
    end
  endtask

  task automatic test_zero_sizes();
    int t0;
    bit to;
    for (int v = 0; v < 2; v++) begin
      int ni;
      int nn;
      ni = (v == 0) ? 16 : 0;
      nn = (v == 0) ? 0 : 3;
      run_layer(ni, nn, 2'd0, 1, -1, t0, to);
      vectors++;
      if (to !== 1'b0 || done_q.size() != 1 || done_q[0] - t0 < 1 || done_q[0] - t0 > 2) begin
        miscompares++;
        $display("FAIL zero_done[%0d]: got n=%0d timeout=%b want one pulse within 2 cycles", v, done_q.size(), to);
      end
      vectors++;
      if (me_q.size() + mc_q.size() + wr_cyc_q.size() != 0) begin
        miscompares++;
        $display("FAIL zero_activity[%0d]: got enables=%0d clears=%0d writes=%0d want 0",
                 v, me_q.size(), mc_q.size(), wr_cyc_q.size());
      end
    end
  endtask

  task automatic test_slow_result();
    int t0;
    bit to;
    fill_random();
    run_layer(13, 2, 2'd1, 5, -1, t0, to);
    vectors++;
    if (to !== 1'b0 || ae_q.size() != 2 || wr_cyc_q.size() != 2) begin
      miscompares++;
      $display("FAIL slow_counts: got act=%0d writes=%0d timeout=%b want 2 2 0", ae_q.size(), wr_cyc_q.size(), to);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (wr_cyc_q[i] - ae_q[i] != 6) begin
          miscompares++; $display("FAIL slow_latency[%0d]: got %0d want 6", i, wr_cyc_q[i] - ae_q[i]);
        end
        vectors++;
        if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== 8'(model(i, 13, 2'd1))) begin
          miscompares++;
          $display("FAIL slow_write[%0d]: got addr %0d data %h want addr %0d data %h",
                   i, wr_addr_q[i], wr_data_q[i], i, 8'(model(i, 13, 2'd1)));
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int t0;
    bit to;
    fill_random();
    run_layer(24, 3, 2'd0, 1, 5, t0, to);
    vectors++;
    if (to !== 1'b0 || done_q.size() != 1 || me_q.size() != 9) begin
      miscompares++;
      $display("FAIL restart_counts: got done=%0d enables=%0d timeout=%b want 1 9 0", done_q.size(), me_q.size(), to);
    end
    vectors++;
    if (wr_addr_q.size() != 3) begin
      miscompares++; $display("FAIL restart_write_count: got %0d want 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== 8'(model(i, 24, 2'd0))) begin
          miscompares++;
          $display("FAIL restart_write[%0d]: got addr %0d data %h want addr %0d data %h",
                   i, wr_addr_q[i], wr_data_q[i], i, 8'(model(i, 24, 2'd0)));
        end
      end
    end
  endtask

  task automatic test_reset_mid_layer();
    int t0;
    bit to;
    int cnt;
    logic [7:0] lane_or;
    fill_random();
    clear_q();
    res_dly = 1;
    @(posedge clk); #1;
    num_inputs = 7'd16; num_neurons = 6'd6; act_type = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 500 && cnt < 7; k++) begin
      @(negedge clk);
      if (mac_enable) cnt++;
    end
    vectors++;
    if (cnt != 7) begin miscompares++; $display("FAIL midreset_reach: got %0d issues want 7", cnt); end
    #1 rst_n = 1'b0;
    #1;
    lane_or = '0;
    for (int l = 0; l < 8; l++) lane_or |= data_out[l] | weight_out[l];
    vectors++;
    if ({busy, done, mac_enable, mac_clear, activation_enable, out_wr_en} !== 6'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: got %b want 000000",
               {busy, done, mac_enable, mac_clear, activation_enable, out_wr_en});
    end
    vectors++;
    if ({lane_or, bias_out, w_rd_addr, in_rd_addr, b_rd_addr, activation_type} !== 34'b0) begin
      miscompares++;
      $display("FAIL midreset_data: got %h want 0", {lane_or, bias_out, w_rd_addr, in_rd_addr, b_rd_addr, activation_type});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    vectors++;
    if (done_q.size() != 0 || wr_addr_q.size() != 3) begin
      miscompares++;
      $display("FAIL midreset_aborted: got done=%0d writes=%0d want 0 3", done_q.size(), wr_addr_q.size());
    end
    run_layer(17, 2, 2'd1, 1, -1, t0, to);
    vectors++;
    if (to !== 1'b0 || done_q.size() != 1 || wr_addr_q.size() != 2) begin
      miscompares++;
      $display("FAIL midreset_rerun: got done=%0d writes=%0d timeout=%b want 1 2 0", done_q.size(), wr_addr_q.size(), to);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== 8'(model(i, 17, 2'd1))) begin
          miscompares++;
          $display("FAIL midreset_write[%0d]: got addr %0d data %h want addr %0d data %h",
                   i, wr_addr_q[i], wr_data_q[i], i, 8'(model(i, 17, 2'd1)));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    bit to;
    for (int r = 0; r < 6; r++) begin
      int ni;
      int nn;
      int ch;
      logic [1:0] at;
      ni = $urandom_range(1, 64);
      nn = $urandom_range(1, 5);
      at = 2'($urandom_range(0, 3));
      ch = (ni + 7) / 8;
      fill_random();
      run_layer(ni, nn, at, $urandom_range(1, 3), -1, t0, to);
      vectors++;
      if (to !== 1'b0 || done_q.size() != 1 || me_q.size() != nn*ch || ae_q.size() != nn) begin
        miscompares++;
        $display("FAIL b2b_counts[%0d]: got done=%0d enables=%0d acts=%0d want 1 %0d %0d (ni=%0d nn=%0d)",
                 r, done_q.size(), me_q.size(), ae_q.size(), nn*ch, nn, ni, nn);
      end
      vectors++;
      if (wr_addr_q.size() != nn) begin
        miscompares++; $display("FAIL b2b_write_count[%0d]: got %0d want %0d", r, wr_addr_q.size(), nn);
      end else begin
        for (int i = 0; i < nn; i++) begin
          vectors++;
          if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== 8'(model(i, ni, at))) begin
            miscompares++;
            $display("FAIL b2b_write[%0d.%0d]: got addr %0d data %h want addr %0d data %h",
                     r, i, wr_addr_q[i], wr_data_q[i], i, 8'(model(i, ni, at)));
          end
        end
      end
    end
  endtask

  task automatic test_strobes();
    vectors++;
    if (viol != 0) begin
      miscompares++; $display("FAIL strobe_exclusive: got %0d bad cycles want 0", viol);
    end
  endtask

  initial begin
    fill_random();
    test_reset();
    test_single_neuron();
    test_partial_chunk();
    test_zero_sizes();
    test_slow_result();
    test_start_ignored();
    test_reset_mid_layer();
    test_back_to_back();
    test_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
